// File: rtl/sr_latch_bank.sv
// sr_latch_bank: bank of synchronous set/reset latches with global clear, conflict priority and snapshot read
module sr_latch_bank #(
    parameter int WIDTH         = 15,
    parameter int RESET_VAL     = 0,
    parameter int CONFLICT      = 0,
    parameter int EDGE_SET      = 0,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] r2,
    input  logic             clr_all,
    input  logic             rd_req,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             any_set,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);
    if (CONFLICT < 0 || CONFLICT > 2) begin : g_bad_conflict
        $error("sr_latch_bank: CONFLICT must be 0, 1 or 2");
    end
    logic [WIDTH-1:0] s_prev, set_ev, rst_ev, conf_val, idle_val, q_next;
    always_comb begin
        set_ev   = (EDGE_SET != 0) ? (s & ~s_prev) : s;
        rst_ev   = r | r2;
        conf_val = (CONFLICT == 1) ? '1 : (CONFLICT == 2) ? '0 : q;
        idle_val = (CLEAR_ON_READ != 0 && rd_req) ? '0 : q;
        q_next   = clr_all ? '0 : (set_ev & ~rst_ev) | (set_ev & rst_ev & conf_val) | (~set_ev & ~rst_ev & idle_val);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q        <= {WIDTH{1'(RESET_VAL)}};
            s_prev   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            q        <= q_next;
            s_prev   <= s;
            rd_valid <= rd_req;
            if (rd_req) rd_data <= q;
        end
    end
    assign q_bar   = ~q;
    assign any_set = |q;
endmodule
